xor_tree_fault_monitor: RTL and testbench



---
 rtl/lfi_pkg.sv | 24 ++
 rtl/ring_oscillator.sv | 17 +
 rtl/xor_reduce_reg.sv | 31 +++
 rtl/xor_tree_fault_monitor.sv | 104 ++++++++++
 tb/tb_xor_tree_fault_monitor.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfi_pkg.sv
// Shared definitions for the laser fault injection target blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package lfi_pkg;

   // Evaluation sequencer states; encoding is shared with host-side decoders.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAP  = 2'd1,
      EVAL = 2'd2,
      CMP  = 2'd3
   } state_t;

   // All-ones value of a w-bit saturating counter (w up to 64).
   function automatic logic [63:0] cnt_max(input int w);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/ring_oscillator.sv
// Locator oscillator used to find the target die area under the laser.
// Latency: ro_out toggles every clk edge while en is high.
// Backpressure: none; free running while enabled.
module ring_oscillator (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic ro_out
);

   // Toggle whenever enabled so the locator draws visible switching current.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ro_out <= 1'b0;
      else if (en) ro_out <= ~ro_out;
   end

endmodule

// File: rtl/xor_reduce_reg.sv
// Captured-operand XOR reduction: capture register feeding a registered parity bit.
// Latency: capture on cap edge, parity on the following eval edge.
// Backpressure: none; enables come from the sequencer.
module xor_reduce_reg #(
   parameter int WIDTH = 32,
   parameter bit INV   = 1'b0,
   parameter bit CORR  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap,
   input  logic             eval,
   input  logic [WIDTH-1:0] d,
   output logic             par
);

   (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] cap_q;

   // Capture the operand (optionally inverted) so later changes on d are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cap_q <= '0;
      else if (cap) cap_q <= INV ? ~d : d;
   end

   // Reduce the captured operand; CORR restores true parity for an inverted odd-width copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par <= 1'b0;
      else if (eval) par <= (^cap_q) ^ CORR;
   end

endmodule

// File: rtl/xor_tree_fault_monitor.sv
// Laser target: registered XOR reduction checked against a separate shadow reduction.
// Latency: start sampled at edge E -> done/q/fault valid after edge E+3; cont gives one result per 3 cycles.
// Backpressure: none; start while busy is dropped, not queued.
module xor_tree_fault_monitor
   import lfi_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int CNT_W      = 16,
   parameter bit SHADOW_INV = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic             start,
   input  logic             cont,
   input  logic             clr,
   input  logic             ro_en,
   output logic             ro_out,
   output logic             busy,
   output logic             done,
   output logic             q,
   output logic             fault,
   output logic             fault_sticky,
   output logic [CNT_W-1:0] fault_count
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
   localparam bit               ODD_CORR = SHADOW_INV && ((WIDTH % 2) == 1);

   state_t state;
   logic   cap_en;
   logic   eval_en;
   logic   q_p;
   logic   q_s;
   logic   mismatch;

   assign cap_en   = (state == CAP);
   assign eval_en  = (state == EVAL);
   assign mismatch = q_p ^ q_s;

   (* dont_touch = "true", keep = "true" *)
   xor_reduce_reg #(.WIDTH(WIDTH), .INV(1'b0), .CORR(1'b0)) u_primary (
      .clk (clk), .rst (rst), .cap (cap_en), .eval (eval_en), .d (a), .par (q_p)
   );

   (* dont_touch = "true", keep = "true" *)
   xor_reduce_reg #(.WIDTH(WIDTH), .INV(SHADOW_INV), .CORR(ODD_CORR)) u_shadow (
      .clk (clk), .rst (rst), .cap (cap_en), .eval (eval_en), .d (a), .par (q_s)
   );

   (* dont_touch = "true" *)
   ring_oscillator u_ro (
      .clk (clk), .rst (rst), .en (ro_en), .ro_out (ro_out)
   );

   // Sequencer with registered outputs plus the saturating fault bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         q            <= 1'b0;
         fault        <= 1'b0;
         fault_sticky <= 1'b0;
         fault_count  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start || cont) begin
                  state <= CAP;
                  busy  <= 1'b1;
               end
            end
            CAP:  state <= EVAL;
            EVAL: state <= CMP;
            CMP: begin
               q     <= q_p;
               fault <= mismatch;
               done  <= 1'b1;
               if (cont) begin
                  state <= CAP;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         // clr wins over a same-cycle increment; the fault output itself is unaffected.
         if (clr) begin
            fault_count  <= '0;
            fault_sticky <= 1'b0;
         end else if ((state == CMP) && mismatch) begin
            fault_sticky <= 1'b1;
            if (fault_count != CNT_MAX) fault_count <= fault_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_xor_tree_fault_monitor.sv
// Self-checking bench for xor_tree_fault_monitor (three parameterisations).
// Latency: n/a.
// Backpressure: n/a.
module tb_xor_tree_fault_monitor;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Main instance: WIDTH=32, CNT_W=16, SHADOW_INV=0
   logic [31:0] a;
   logic start, cont, clr, ro_en;
   logic ro_out, busy, done, q, fault, fault_sticky;
   logic [15:0] fault_count;

   // Saturation instance: CNT_W=2
   logic start2, cont2, clr2;
   logic ro2, busy2, done2, q2, fault2, sticky2;
   logic [1:0] count2;

   // Inverted shadow instance: WIDTH=5, SHADOW_INV=1
   logic [4:0] a3;
   logic start3, cont3, clr3;
   logic ro3, busy3, done3, q3, fault3, sticky3;
   logic [15:0] count3;

   xor_tree_fault_monitor #(.WIDTH(32), .CNT_W(16), .SHADOW_INV(1'b0)) dut (
      .clk(clk), .rst(rst), .a(a), .start(start), .cont(cont), .clr(clr), .ro_en(ro_en),
      .ro_out(ro_out), .busy(busy), .done(done), .q(q), .fault(fault),
      .fault_sticky(fault_sticky), .fault_count(fault_count)
   );

   xor_tree_fault_monitor #(.WIDTH(32), .CNT_W(2), .SHADOW_INV(1'b0)) dut2 (
      .clk(clk), .rst(rst), .a(a), .start(start2), .cont(cont2), .clr(clr2), .ro_en(ro_en),
      .ro_out(ro2), .busy(busy2), .done(done2), .q(q2), .fault(fault2),
      .fault_sticky(sticky2), .fault_count(count2)
   );

   xor_tree_fault_monitor #(.WIDTH(5), .CNT_W(16), .SHADOW_INV(1'b1)) dut3 (
      .clk(clk), .rst(rst), .a(a3), .start(start3), .cont(cont3), .clr(clr3), .ro_en(ro_en),
      .ro_out(ro3), .busy(busy3), .done(done3), .q(q3), .fault(fault3),
      .fault_sticky(sticky3), .fault_count(count3)
   );

   typedef struct {
      logic [31:0] a;
      logic        exp_q;
   } vec_t;

   vec_t tbl[6];
   int   dn[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference parity: count the set bits among the low w bits and take the remainder mod 2.
   function automatic logic ref_parity(input logic [31:0] v, input int w);
      int n;
      n = 0;
      for (int i = 0; i < w; i++) begin
         if (v[i]) n++;
      end
      return logic'(n % 2);
   endfunction

   // Pulse start on the main instance and count cycles from the sampling edge to done.
   task automatic run_one(input logic [31:0] av, output int lat);
      a     = av;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      while (done !== 1'b1 && lat < 12) begin
         tick();
         lat++;
      end
      check("done_seen", done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, extra, ro_changes;
      logic [31:0] r;
      logic [4:0]  r3;
      logic        prev_ro;

      tbl[0] = '{32'hFFFF_FFFF, 1'b0};
      tbl[1] = '{32'h0000_0001, 1'b1};
      tbl[2] = '{32'h0000_0000, 1'b0};
      tbl[3] = '{32'h8000_0000, 1'b1};
      tbl[4] = '{32'hA5A5_A5A5, 1'b0};
      tbl[5] = '{32'h0000_0007, 1'b1};

      rst = 1'b1; a = '0; start = 0; cont = 0; clr = 0; ro_en = 0;
      start2 = 0; cont2 = 0; clr2 = 0;
      a3 = '0; start3 = 0; cont3 = 0; clr3 = 0;
      repeat (2) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", q, 0);
      check("rst_fault", fault, 0);
      check("rst_sticky", fault_sticky, 0);
      check("rst_count", fault_count, 0);
      check("rst_ro", ro_out, 0);
      rst = 1'b0;
      tick();

      // Table-driven single evaluations: latency, result, pulse width
      for (int i = 0; i < 6; i++) begin
         run_one(tbl[i].a, lat);
         check("tbl_latency", lat, 3);
         check("tbl_q", q, tbl[i].exp_q);
         check("tbl_fault", fault, 0);
         tick();
         check("tbl_done_width", done, 0);
         check("tbl_q_hold", q, tbl[i].exp_q);
      end
      check("tbl_count", fault_count, 0);

      // Capture isolation: a changes one cycle after the capture edge
      a = 32'h1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 32'h3;
      tick();
      tick();
      check("iso_done", done, 1);
      check("iso_q", q, 1);

      // Two forced shadow mismatches, then clear
      force dut.u_shadow.par = 1'b1;
      for (int k = 0; k < 2; k++) begin
         run_one(32'h0, lat);
         check("force_fault", fault, 1);
         check("force_q", q, 0);
         tick();
      end
      release dut.u_shadow.par;
      check("force_count", fault_count, 2);
      check("force_sticky", fault_sticky, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_count", fault_count, 0);
      check("clr_sticky", fault_sticky, 0);

      // Continuous mode with a=7
      a = 32'h7; cont = 1'b1;
      dn.delete();
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (done) begin
            dn.push_back(i);
            check("cont_q", q, 1);
         end
      end
      check("cont_pulses", dn.size(), 3);
      if (dn.size() >= 3) begin
         check("cont_first", dn[0], 4);
         check("cont_gap1", dn[1] - dn[0], 3);
         check("cont_gap2", dn[2] - dn[1], 3);
      end
      cont = 1'b0;
      n = 0; extra = 0;
      while (busy && n < 10) begin
         tick();
         n++;
         if (done) extra++;
      end
      check("cont_drain_dones", extra, 1);
      check("cont_drain_busy", busy, 0);
      check("cont_drain_q", q, 1);

      // Random operands; a is re-randomised after capture and start is pulsed while busy
      for (int k = 0; k < 20; k++) begin
         r = $urandom;
         a = r; start = 1'b1;
         tick();
         start = 1'b0;
         tick();
         a = $urandom; start = 1'b1;
         tick();
         start = 1'b0;
         tick();
         check("rnd_done", done, 1);
         check("rnd_q", q, ref_parity(r, 32));
         check("rnd_fault", fault, 0);
         check("rnd_busy", busy, 0);
         tick();
         check("rnd_not_queued", busy, 0);
         repeat ($urandom_range(0, 2)) tick();
      end
      check("rnd_count", fault_count, 0);

      // Set up nonzero outputs, then reset during EVAL
      force dut.u_shadow.par = 1'b0;
      run_one(32'h1, lat);
      check("pre_rst_fault", fault, 1);
      tick();
      release dut.u_shadow.par;
      a = 32'h7; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_q", q, 0);
      check("mid_rst_fault", fault, 0);
      check("mid_rst_sticky", fault_sticky, 0);
      check("mid_rst_count", fault_count, 0);
      extra = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (done) extra++;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) extra++;
      end
      check("mid_rst_no_done", extra, 0);
      run_one(32'h7, lat);
      check("post_rst_latency", lat, 3);
      check("post_rst_q", q, 1);
      check("post_rst_fault", fault, 0);
      tick();

      // CNT_W=2: saturation at 3, then clr coincident with a mismatch
      force dut2.u_shadow.par = 1'b1;
      a = 32'h0;
      for (int k = 0; k < 4; k++) begin
         start2 = 1'b1;
         tick();
         start2 = 1'b0;
         n = 0;
         while (done2 !== 1'b1 && n < 12) begin
            tick();
            n++;
         end
         check("sat_done", done2, 1);
         check("sat_fault", fault2, 1);
         tick();
      end
      check("sat_count", count2, 3);
      check("sat_sticky", sticky2, 1);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      tick();
      tick();
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      check("clr_mm_done", done2, 1);
      check("clr_mm_fault", fault2, 1);
      check("clr_mm_count", count2, 0);
      check("clr_mm_sticky", sticky2, 0);
      release dut2.u_shadow.par;

      // Inverted shadow on odd width
      a3 = 5'b10110; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      repeat (3) tick();
      check("inv_done", done3, 1);
      check("inv_q", q3, 1);
      check("inv_fault", fault3, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         r3 = 5'($urandom);
         r  = {27'd0, r3};
         a3 = r3; start3 = 1'b1;
         tick();
         start3 = 1'b0;
         repeat (3) tick();
         check("inv_rnd_done", done3, 1);
         check("inv_rnd_q", q3, ref_parity(r, 5));
         check("inv_rnd_fault", fault3, 0);
      end
      check("inv_count", count3, 0);

      // Locator oscillator activity when enabled
      ro_en = 1'b1;
      ro_changes = 0;
      prev_ro = ro_out;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ro_out !== prev_ro) ro_changes++;
         prev_ro = ro_out;
      end
      check("ro_active", (ro_changes > 0), 1);
      ro_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
